conv11_ctrl: RTL and testbench

Sequencer for the 1x1 convolution datapath: walks output-channel / pixel / input-channel loops, issues feature-map and weight buffer reads, and drives the MAC unit's enable, accumulate-clear and last strobes. It also produces the bias/scale index and output-buffer write address.
Sits between the layer scheduler (start/config/done) and the conv11 calc unit plus its on-chip buffers.
One MAC issue per cycle when not stalled.

---
 rtl/conv11_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_conv11_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv11_ctrl.sv
// conv11_ctrl: loop sequencer for the 1x1 convolution datapath.
//   Walks oc (outer) / pix / ic (inner) loops. It issues one feature-map and
//   weight read per unstalled cycle, then delays the MAC strobes through the
//   read and calc latencies.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   start, cfg_pix_num/in_ch/out_ch  layer start pulse and layer sizes
//   stall                            blocks new issue; in-flight strobes keep moving
//   busy, done                       layer status; done is a one-cycle pulse
//   fm_rd_en/addr, wt_rd_en/addr     buffer read requests
//   calc_en, acc_clr, acc_last       MAC controls, RD_LATENCY after the read
//   bias_idx                         output channel, aligned with calc_en
//   out_wr_en/addr                   result write, CALC_LATENCY after acc_last
// Optional: define CONV11_CTRL_PERF_EN to add perf_busy_cyc / perf_stall_cyc.
module conv11_ctrl #(
  parameter int ADDR_WIDTH   = 16,
  parameter int CNT_WIDTH    = 10,
  parameter int RD_LATENCY   = 1,
  parameter int CALC_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  cfg_pix_num,
  input  logic [CNT_WIDTH-1:0]  cfg_in_ch,
  input  logic [CNT_WIDTH-1:0]  cfg_out_ch,
  input  logic                  stall,
`ifdef CONV11_CTRL_PERF_EN
  output logic [31:0]           perf_busy_cyc,
  output logic [31:0]           perf_stall_cyc,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  fm_rd_en,
  output logic [ADDR_WIDTH-1:0] fm_rd_addr,
  output logic                  wt_rd_en,
  output logic [ADDR_WIDTH-1:0] wt_rd_addr,
  output logic [CNT_WIDTH-1:0]  bias_idx,
  output logic                  calc_en,
  output logic                  acc_clr,
  output logic                  acc_last,
  output logic                  out_wr_en,
  output logic [ADDR_WIDTH-1:0] out_wr_addr
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, FIN = 2'd3} state_t;

  localparam int DRAIN_LAST = RD_LATENCY + CALC_LATENCY - 1;
  localparam int DW         = $clog2(RD_LATENCY + CALC_LATENCY + 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ZERO = CNT_WIDTH'(0);

  state_t                state_r;
  logic [DW-1:0]         drain_cnt_r;
  logic [CNT_WIDTH-1:0]  pix_num_r, in_ch_r, out_ch_r;
  logic [CNT_WIDTH-1:0]  oc_r, pix_r, ic_r;
  logic [ADDR_WIDTH-1:0] fm_cnt_r, wt_cnt_r, wt_base_r, out_cnt_r;
  logic                  busy_r, done_r;
  // Issue-stage registers: the read request plus the tags that ride along with it
  logic                  fm_rd_en_r, issue_clr_r, issue_last_r;
  logic [ADDR_WIDTH-1:0] fm_rd_addr_r, wt_rd_addr_r, issue_oaddr_r;
  logic [CNT_WIDTH-1:0]  issue_oc_r;
  // Read-latency delay line and calc-latency delay line
  logic                  rd_en_q   [RD_LATENCY];
  logic                  rd_clr_q  [RD_LATENCY];
  logic                  rd_last_q [RD_LATENCY];
  logic [CNT_WIDTH-1:0]  rd_oc_q   [RD_LATENCY];
  logic [ADDR_WIDTH-1:0] rd_oaddr_q[RD_LATENCY];
  logic                  wr_en_q   [CALC_LATENCY];
  logic [ADDR_WIDTH-1:0] wr_addr_q [CALC_LATENCY];

  logic last_ic_s, last_pix_s, last_oc_s, cfg_zero_s;

  // Loop-boundary detection for the current issue position
  always_comb begin
    last_ic_s  = (ic_r  == in_ch_r   - CNT_ONE);
    last_pix_s = (pix_r == pix_num_r - CNT_ONE);
    last_oc_s  = (oc_r  == out_ch_r  - CNT_ONE);
    cfg_zero_s = (cfg_pix_num == CNT_ZERO) || (cfg_in_ch == CNT_ZERO) ||
                 (cfg_out_ch == CNT_ZERO);
  end

  // Sequencer FSM: loop counters, incremental addresses and issue-stage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;       drain_cnt_r <= '0;
      pix_num_r <= '0;       in_ch_r <= '0;        out_ch_r <= '0;
      oc_r <= '0;            pix_r <= '0;          ic_r <= '0;
      fm_cnt_r <= '0;        wt_cnt_r <= '0;       wt_base_r <= '0;   out_cnt_r <= '0;
      busy_r <= 1'b0;        done_r <= 1'b0;
      fm_rd_en_r <= 1'b0;    issue_clr_r <= 1'b0;  issue_last_r <= 1'b0;
      fm_rd_addr_r <= '0;    wt_rd_addr_r <= '0;   issue_oaddr_r <= '0; issue_oc_r <= '0;
    end else begin
      fm_rd_en_r   <= 1'b0;
      issue_clr_r  <= 1'b0;
      issue_last_r <= 1'b0;
      done_r       <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            pix_num_r <= cfg_pix_num;
            in_ch_r   <= cfg_in_ch;
            out_ch_r  <= cfg_out_ch;
            oc_r <= '0; pix_r <= '0; ic_r <= '0;
            fm_cnt_r <= '0; wt_cnt_r <= '0; wt_base_r <= '0; out_cnt_r <= '0;
            busy_r  <= 1'b1;
            state_r <= cfg_zero_s ? FIN : ISSUE;
          end
        end
        ISSUE: begin
          if (!stall) begin
            fm_rd_en_r    <= 1'b1;
            fm_rd_addr_r  <= fm_cnt_r;
            wt_rd_addr_r  <= wt_cnt_r;
            issue_clr_r   <= (ic_r == CNT_ZERO);
            issue_last_r  <= last_ic_s;
            issue_oc_r    <= oc_r;
            issue_oaddr_r <= out_cnt_r;
            if (!last_ic_s) begin
              ic_r     <= ic_r + CNT_ONE;
              fm_cnt_r <= fm_cnt_r + ADDR_WIDTH'(pix_num_r);
              wt_cnt_r <= wt_cnt_r + ADDR_ONE;
            end else begin
              // oc*pix_num + pix is simply a running pixel count
              ic_r      <= '0;
              out_cnt_r <= out_cnt_r + ADDR_ONE;
              if (!last_pix_s) begin
                pix_r    <= pix_r + CNT_ONE;
                fm_cnt_r <= ADDR_WIDTH'(pix_r) + ADDR_ONE;
                wt_cnt_r <= wt_base_r;
              end else begin
                pix_r     <= '0;
                fm_cnt_r  <= '0;
                wt_base_r <= wt_base_r + ADDR_WIDTH'(in_ch_r);
                wt_cnt_r  <= wt_base_r + ADDR_WIDTH'(in_ch_r);
                if (last_oc_s) begin
                  drain_cnt_r <= '0;
                  state_r     <= DRAIN;
                end else begin
                  oc_r <= oc_r + CNT_ONE;
                end
              end
            end
          end
        end
        DRAIN: begin
          // Hold until the last issued read has produced its result write
          if (drain_cnt_r == DW'(DRAIN_LAST)) begin
            state_r <= FIN;
          end else begin
            drain_cnt_r <= drain_cnt_r + DW'(1);
          end
        end
        FIN: begin
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Free-running delay lines: stall never freezes strobes already in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        rd_en_q[i] <= 1'b0; rd_clr_q[i] <= 1'b0; rd_last_q[i] <= 1'b0;
        rd_oc_q[i] <= '0;   rd_oaddr_q[i] <= '0;
      end
      for (int i = 0; i < CALC_LATENCY; i++) begin
        wr_en_q[i] <= 1'b0; wr_addr_q[i] <= '0;
      end
    end else begin
      rd_en_q[0]    <= fm_rd_en_r;
      rd_clr_q[0]   <= issue_clr_r;
      rd_last_q[0]  <= issue_last_r;
      rd_oc_q[0]    <= issue_oc_r;
      rd_oaddr_q[0] <= issue_oaddr_r;
      for (int i = 1; i < RD_LATENCY; i++) begin
        rd_en_q[i]    <= rd_en_q[i-1];
        rd_clr_q[i]   <= rd_clr_q[i-1];
        rd_last_q[i]  <= rd_last_q[i-1];
        rd_oc_q[i]    <= rd_oc_q[i-1];
        rd_oaddr_q[i] <= rd_oaddr_q[i-1];
      end
      wr_en_q[0]   <= rd_en_q[RD_LATENCY-1] && rd_last_q[RD_LATENCY-1];
      wr_addr_q[0] <= rd_oaddr_q[RD_LATENCY-1];
      for (int i = 1; i < CALC_LATENCY; i++) begin
        wr_en_q[i]   <= wr_en_q[i-1];
        wr_addr_q[i] <= wr_addr_q[i-1];
      end
    end
  end

`ifdef CONV11_CTRL_PERF_EN
  logic [31:0] perf_busy_r, perf_stall_r;

  // Saturating layer performance counters, cleared on an accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy_r  <= 32'd0;
      perf_stall_r <= 32'd0;
    end else if ((state_r == IDLE) && start) begin
      perf_busy_r  <= 32'd0;
      perf_stall_r <= 32'd0;
    end else begin
      if (busy_r && (perf_busy_r != 32'hFFFF_FFFF)) begin
        perf_busy_r <= perf_busy_r + 32'd1;
      end
      if ((state_r == ISSUE) && stall && (perf_stall_r != 32'hFFFF_FFFF)) begin
        perf_stall_r <= perf_stall_r + 32'd1;
      end
    end
  end

  assign perf_busy_cyc  = perf_busy_r;
  assign perf_stall_cyc = perf_stall_r;
`endif

  assign busy        = busy_r;
  assign done        = done_r;
  assign fm_rd_en    = fm_rd_en_r;
  assign wt_rd_en    = fm_rd_en_r;
  assign fm_rd_addr  = fm_rd_addr_r;
  assign wt_rd_addr  = wt_rd_addr_r;
  assign calc_en     = rd_en_q[RD_LATENCY-1];
  assign acc_clr     = rd_clr_q[RD_LATENCY-1];
  assign acc_last    = rd_last_q[RD_LATENCY-1];
  assign bias_idx    = rd_oc_q[RD_LATENCY-1];
  assign out_wr_en   = wr_en_q[CALC_LATENCY-1];
  assign out_wr_addr = wr_addr_q[CALC_LATENCY-1];

endmodule

// File: tb/tb_conv11_ctrl.sv
// Directed bench for conv11_ctrl: instance a uses default latencies (1,1),
// instance b uses RD_LATENCY=2, CALC_LATENCY=3; both share the stimulus.
module tb_conv11_ctrl;
  localparam int AW = 16;
  localparam int CW = 10;

  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, stall = 1'b0;
  logic [CW-1:0] cfg_pix_num = '0, cfg_in_ch = '0, cfg_out_ch = '0;

  logic a_busy, a_done, a_fm_en, a_wt_en, a_calc, a_clr, a_last, a_wr_en;
  logic [AW-1:0] a_fm_addr, a_wt_addr, a_wr_addr;
  logic [CW-1:0] a_bias;
  logic b_busy, b_done, b_fm_en, b_wt_en, b_calc, b_clr, b_last, b_wr_en;
  logic [AW-1:0] b_fm_addr, b_wt_addr, b_wr_addr;
  logic [CW-1:0] b_bias;
`ifdef CONV11_CTRL_PERF_EN
  logic [31:0] a_pbusy, a_pstall, b_pbusy, b_pstall;
`endif

  conv11_ctrl u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_pix_num(cfg_pix_num),
    .cfg_in_ch(cfg_in_ch), .cfg_out_ch(cfg_out_ch), .stall(stall),
`ifdef CONV11_CTRL_PERF_EN
    .perf_busy_cyc(a_pbusy), .perf_stall_cyc(a_pstall),
`endif
    .busy(a_busy), .done(a_done), .fm_rd_en(a_fm_en), .fm_rd_addr(a_fm_addr),
    .wt_rd_en(a_wt_en), .wt_rd_addr(a_wt_addr), .bias_idx(a_bias), .calc_en(a_calc),
    .acc_clr(a_clr), .acc_last(a_last), .out_wr_en(a_wr_en), .out_wr_addr(a_wr_addr));

  conv11_ctrl #(.RD_LATENCY(2), .CALC_LATENCY(3)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_pix_num(cfg_pix_num),
    .cfg_in_ch(cfg_in_ch), .cfg_out_ch(cfg_out_ch), .stall(stall),
`ifdef CONV11_CTRL_PERF_EN
    .perf_busy_cyc(b_pbusy), .perf_stall_cyc(b_pstall),
`endif
    .busy(b_busy), .done(b_done), .fm_rd_en(b_fm_en), .fm_rd_addr(b_fm_addr),
    .wt_rd_en(b_wt_en), .wt_rd_addr(b_wt_addr), .bias_idx(b_bias), .calc_en(b_calc),
    .acc_clr(b_clr), .acc_last(b_last), .out_wr_en(b_wr_en), .out_wr_addr(b_wr_addr));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Hand-computed sequences for pix=2, in=3, out=2
  int EXP_FM[12]   = '{0, 2, 4, 1, 3, 5, 0, 2, 4, 1, 3, 5};
  int EXP_WT[12]   = '{0, 1, 2, 0, 1, 2, 3, 4, 5, 3, 4, 5};
  int EXP_BIAS[12] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};

  int a_en_cyc[$], a_fm[$], a_wt[$], a_calc_cyc[$], a_bias_q[$], a_clr_cyc[$];
  int a_last_cyc[$], a_wr_cyc[$], a_wr[$], a_done_cyc[$];
  int a_wten_bad = 0;
  int b_en_cyc[$], b_calc_cyc[$], b_last_cyc[$], b_wr_cyc[$], b_wr[$], b_done_cyc[$];

  // Event recorders, sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_fm_en !== a_wt_en) a_wten_bad = a_wten_bad + 1;
      if (a_fm_en) begin a_en_cyc.push_back(cyc); a_fm.push_back(int'(a_fm_addr)); a_wt.push_back(int'(a_wt_addr)); end
      if (a_calc) begin a_calc_cyc.push_back(cyc); a_bias_q.push_back(int'(a_bias)); end
      if (a_clr) a_clr_cyc.push_back(cyc);
      if (a_last) a_last_cyc.push_back(cyc);
      if (a_wr_en) begin a_wr_cyc.push_back(cyc); a_wr.push_back(int'(a_wr_addr)); end
      if (a_done) a_done_cyc.push_back(cyc);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (b_fm_en) b_en_cyc.push_back(cyc);
      if (b_calc) b_calc_cyc.push_back(cyc);
      if (b_last) b_last_cyc.push_back(cyc);
      if (b_wr_en) begin b_wr_cyc.push_back(cyc); b_wr.push_back(int'(b_wr_addr)); end
      if (b_done) b_done_cyc.push_back(cyc);
    end
  end

  int total = 0;
  int bad = 0;

  // Start pulse; sc is the cycle in which start is high
  task automatic pulse_start(input int p, input int i, input int o, output int sc);
    @(negedge clk);
    cfg_pix_num = CW'(p); cfg_in_ch = CW'(i); cfg_out_ch = CW'(o);
    start = 1'b1;
    sc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_a_done(input int base);
    for (int k = 0; k < 300 && a_done_cyc.size() == base; k++) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [63:0] obs;
    #2 rst_n = 1'b0;
    #1;
    obs = {a_busy, a_done, a_fm_en, a_wt_en, a_calc, a_clr, a_last, a_wr_en,
           a_fm_addr, a_wt_addr, a_wr_addr, a_bias[5:0]};
    total++;
    if (obs !== 64'd0) begin bad++; $display("FAIL reset_outputs got=%h want=0", obs); end
    #20 rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    int sc, eb, cb, lb, wb, db, clb;
    eb = a_en_cyc.size(); cb = a_calc_cyc.size(); lb = a_last_cyc.size();
    wb = a_wr.size(); db = a_done_cyc.size(); clb = a_clr_cyc.size();
    pulse_start(2, 3, 2, sc);
    wait_a_done(db);
    repeat (10) @(negedge clk);
    total++;
    if (a_done_cyc.size() - db !== 1) begin bad++; $display("FAIL basic_done_count got=%0d want=1", a_done_cyc.size() - db); end
    else begin
      total++;
      if (a_done_cyc[db] - sc !== 16) begin bad++; $display("FAIL basic_done_latency got=%0d want=16", a_done_cyc[db] - sc); end
    end
    total++;
    if (a_en_cyc.size() - eb !== 12 || a_calc_cyc.size() - cb !== 12) begin
      bad++; $display("FAIL basic_issue_count got=%0d/%0d want=12", a_en_cyc.size() - eb, a_calc_cyc.size() - cb);
    end else begin
      for (int i = 0; i < 12; i++) begin
        total++;
        if (a_fm[eb+i] !== EXP_FM[i] || a_wt[eb+i] !== EXP_WT[i] || a_en_cyc[eb+i] !== sc + 2 + i) begin
          bad++; $display("FAIL basic_issue[%0d] got fm=%0d wt=%0d cyc=%0d want fm=%0d wt=%0d cyc=%0d",
                          i, a_fm[eb+i], a_wt[eb+i], a_en_cyc[eb+i] - sc, EXP_FM[i], EXP_WT[i], 2 + i);
        end
        total++;
        if (a_calc_cyc[cb+i] !== a_en_cyc[eb+i] + 1 || a_bias_q[cb+i] !== EXP_BIAS[i]) begin
          bad++; $display("FAIL basic_calc[%0d] got lag=%0d bias=%0d want lag=1 bias=%0d",
                          i, a_calc_cyc[cb+i] - a_en_cyc[eb+i], a_bias_q[cb+i], EXP_BIAS[i]);
        end
      end
    end
    total++;
    if (a_clr_cyc.size() - clb !== 4 || a_last_cyc.size() - lb !== 4) begin
      bad++; $display("FAIL basic_clr_last got=%0d/%0d want=4/4", a_clr_cyc.size() - clb, a_last_cyc.size() - lb);
    end else begin
      total++;
      if (a_clr_cyc[clb] !== sc + 3 || a_last_cyc[lb] !== sc + 5) begin
        bad++; $display("FAIL basic_clr_last_pos got=%0d/%0d want=3/5", a_clr_cyc[clb] - sc, a_last_cyc[lb] - sc);
      end
    end
    total++;
    if (a_wr.size() - wb !== 4) begin bad++; $display("FAIL basic_wr_count got=%0d want=4", a_wr.size() - wb); end
    else begin
      for (int j = 0; j < 4; j++) begin
        total++;
        if (a_wr[wb+j] !== j || a_wr_cyc[wb+j] !== a_last_cyc[lb+j] + 1) begin
          bad++; $display("FAIL basic_wr[%0d] got addr=%0d lag=%0d want addr=%0d lag=1",
                          j, a_wr[wb+j], a_wr_cyc[wb+j] - a_last_cyc[lb+j], j);
        end
      end
    end
    total++;
    if (a_wten_bad !== 0) begin bad++; $display("FAIL wt_rd_en_tracks got=%0d want=0", a_wten_bad); end
`ifdef CONV11_CTRL_PERF_EN
    total++;
    if (a_pbusy !== 32'd15 || a_pstall !== 32'd0) begin
      bad++; $display("FAIL basic_perf got=%0d/%0d want=15/0", a_pbusy, a_pstall);
    end
`endif
  endtask

  task automatic test_stall;
    int sc, eb, db, clb, lb;
    eb = a_en_cyc.size(); db = a_done_cyc.size(); clb = a_clr_cyc.size(); lb = a_last_cyc.size();
    pulse_start(2, 3, 2, sc);
    while (cyc < sc + 5) @(negedge clk);
    stall = 1'b1;
    while (cyc < sc + 8) @(negedge clk);
    stall = 1'b0;
    wait_a_done(db);
    repeat (10) @(negedge clk);
    total++;
    if (a_done_cyc.size() - db !== 1) begin bad++; $display("FAIL stall_done_count got=%0d want=1", a_done_cyc.size() - db); end
    else begin
      total++;
      if (a_done_cyc[db] - sc !== 19) begin bad++; $display("FAIL stall_done_latency got=%0d want=19", a_done_cyc[db] - sc); end
    end
    total++;
    if (a_en_cyc.size() - eb !== 12) begin bad++; $display("FAIL stall_issue_count got=%0d want=12", a_en_cyc.size() - eb); end
    else begin
      for (int i = 0; i < 12; i++) begin
        total++;
        if (a_fm[eb+i] !== EXP_FM[i] || a_wt[eb+i] !== EXP_WT[i] ||
            a_en_cyc[eb+i] - sc !== ((i < 4) ? 2 + i : 5 + i)) begin
          bad++; $display("FAIL stall_issue[%0d] got fm=%0d wt=%0d cyc=%0d want fm=%0d wt=%0d cyc=%0d",
                          i, a_fm[eb+i], a_wt[eb+i], a_en_cyc[eb+i] - sc, EXP_FM[i], EXP_WT[i], (i < 4) ? 2 + i : 5 + i);
        end
      end
    end
    total++;
    if (a_clr_cyc.size() - clb !== 4 || a_last_cyc.size() - lb !== 4) begin
      bad++; $display("FAIL stall_clr_last got=%0d/%0d want=4/4", a_clr_cyc.size() - clb, a_last_cyc.size() - lb);
    end
`ifdef CONV11_CTRL_PERF_EN
    total++;
    if (a_pbusy !== 32'd18 || a_pstall !== 32'd3) begin
      bad++; $display("FAIL stall_perf got=%0d/%0d want=18/3", a_pbusy, a_pstall);
    end
`endif
  endtask

  task automatic test_zero_cfg;
    int sc, eb, cb, wb, db;
    eb = a_en_cyc.size(); cb = a_calc_cyc.size(); wb = a_wr.size(); db = a_done_cyc.size();
    pulse_start(2, 0, 2, sc);
    wait_a_done(db);
    repeat (10) @(negedge clk);
    total++;
    if (a_done_cyc.size() - db !== 1) begin bad++; $display("FAIL zero_done_count got=%0d want=1", a_done_cyc.size() - db); end
    else begin
      total++;
      if (a_done_cyc[db] - sc !== 2) begin bad++; $display("FAIL zero_done_latency got=%0d want=2", a_done_cyc[db] - sc); end
    end
    total++;
    if (a_en_cyc.size() != eb || a_calc_cyc.size() != cb || a_wr.size() != wb) begin
      bad++; $display("FAIL zero_no_strobes got=%0d/%0d/%0d want=0/0/0",
                      a_en_cyc.size() - eb, a_calc_cyc.size() - cb, a_wr.size() - wb);
    end
  endtask

  task automatic test_start_ignored;
    int sc, eb, db;
    eb = a_en_cyc.size(); db = a_done_cyc.size();
    pulse_start(2, 3, 2, sc);
    while (cyc < sc + 6) @(negedge clk);
    cfg_pix_num = CW'(1); cfg_in_ch = CW'(1); cfg_out_ch = CW'(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < sc + 15) @(negedge clk);
    start = 1'b1;   // lands in the FIN cycle
    @(negedge clk);
    start = 1'b0;
    wait_a_done(db);
    repeat (12) @(negedge clk);
    total++;
    if (a_done_cyc.size() - db !== 1) begin bad++; $display("FAIL restart_done_count got=%0d want=1", a_done_cyc.size() - db); end
    else begin
      total++;
      if (a_done_cyc[db] - sc !== 16) begin bad++; $display("FAIL restart_done_latency got=%0d want=16", a_done_cyc[db] - sc); end
    end
    total++;
    if (a_en_cyc.size() - eb !== 12) begin bad++; $display("FAIL restart_issue_count got=%0d want=12", a_en_cyc.size() - eb); end
    else begin
      for (int i = 0; i < 12; i++) begin
        total++;
        if (a_fm[eb+i] !== EXP_FM[i] || a_wt[eb+i] !== EXP_WT[i]) begin
          bad++; $display("FAIL restart_addr[%0d] got fm=%0d wt=%0d want fm=%0d wt=%0d", i, a_fm[eb+i], a_wt[eb+i], EXP_FM[i], EXP_WT[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int sc, eb, db;
    logic [63:0] obs;
    pulse_start(2, 3, 2, sc);
    while (cyc < sc + 6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    obs = {a_busy, a_done, a_fm_en, a_wt_en, a_calc, a_clr, a_last, a_wr_en,
           a_fm_addr, a_wt_addr, a_wr_addr, a_bias[5:0]};
    total++;
    if (obs !== 64'd0) begin bad++; $display("FAIL midreset_outputs got=%h want=0", obs); end
    total++;
    if ({b_busy, b_fm_en, b_calc, b_wr_en, b_fm_addr} !== 20'd0) begin
      bad++; $display("FAIL midreset_outputs_b got=%h want=0", {b_busy, b_fm_en, b_calc, b_wr_en, b_fm_addr});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    eb = a_en_cyc.size(); db = a_done_cyc.size();
    pulse_start(2, 3, 2, sc);
    wait_a_done(db);
    repeat (10) @(negedge clk);
    total++;
    if (a_done_cyc.size() - db !== 1 || a_en_cyc.size() - eb !== 12) begin
      bad++; $display("FAIL midreset_restart got done=%0d issues=%0d want done=1 issues=12",
                      a_done_cyc.size() - db, a_en_cyc.size() - eb);
    end else begin
      for (int i = 0; i < 12; i++) begin
        total++;
        if (a_fm[eb+i] !== EXP_FM[i] || a_wt[eb+i] !== EXP_WT[i]) begin
          bad++; $display("FAIL midreset_addr[%0d] got fm=%0d wt=%0d want fm=%0d wt=%0d", i, a_fm[eb+i], a_wt[eb+i], EXP_FM[i], EXP_WT[i]);
        end
      end
    end
  endtask

  task automatic test_latency;
    int sc, eb, cb, lb, wb, db;
    eb = b_en_cyc.size(); cb = b_calc_cyc.size(); lb = b_last_cyc.size();
    wb = b_wr.size(); db = b_done_cyc.size();
    pulse_start(2, 3, 2, sc);
    for (int k = 0; k < 300 && b_done_cyc.size() == db; k++) @(negedge clk);
    repeat (10) @(negedge clk);
    total++;
    if (b_done_cyc.size() - db !== 1) begin bad++; $display("FAIL lat_done_count got=%0d want=1", b_done_cyc.size() - db); end
    else begin
      total++;
      if (b_done_cyc[db] - sc !== 19) begin bad++; $display("FAIL lat_done_latency got=%0d want=19", b_done_cyc[db] - sc); end
    end
    total++;
    if (b_en_cyc.size() - eb !== 12 || b_calc_cyc.size() - cb !== 12) begin
      bad++; $display("FAIL lat_issue_count got=%0d/%0d want=12", b_en_cyc.size() - eb, b_calc_cyc.size() - cb);
    end else begin
      for (int i = 0; i < 12; i++) begin
        total++;
        if (b_calc_cyc[cb+i] - b_en_cyc[eb+i] !== 2) begin
          bad++; $display("FAIL lat_calc_lag[%0d] got=%0d want=2", i, b_calc_cyc[cb+i] - b_en_cyc[eb+i]);
        end
      end
    end
    total++;
    if (b_wr.size() - wb !== 4 || b_last_cyc.size() - lb !== 4) begin
      bad++; $display("FAIL lat_wr_count got=%0d/%0d want=4/4", b_wr.size() - wb, b_last_cyc.size() - lb);
    end else begin
      for (int j = 0; j < 4; j++) begin
        total++;
        if (b_wr[wb+j] !== j || b_wr_cyc[wb+j] - b_last_cyc[lb+j] !== 3) begin
          bad++; $display("FAIL lat_wr[%0d] got addr=%0d lag=%0d want addr=%0d lag=3",
                          j, b_wr[wb+j], b_wr_cyc[wb+j] - b_last_cyc[lb+j], j);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero_cfg();
    test_start_ignored();
    test_reset_mid();
    test_latency();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
